// File: rtl/ps2_arrow_if.sv
// Bundles the PS/2 line inputs and the decoded direction/debug outputs of ps2_arrow_decoder.
// The master side is the keyboard/consumer end; the slave side is the decoder.
interface ps2_arrow_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  up, down, left, right, rx_byte, byte_valid, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output up, down, left, right, rx_byte, byte_valid, frame_err
    );
endinterface

// File: rtl/ps2_arrow_decoder.sv
// PS/2 Set-2 receiver and arrow-key decoder producing level-held direction flags.
// Optional macro PS2_WASD_EN: non-extended W/S/A/D also drive up/down/left/right.
module ps2_arrow_decoder #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic       clk,
    input  logic       rst_sys,
    ps2_arrow_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
`ifdef PS2_WASD_EN
    localparam logic [7:0] CODE_W     = 8'h1D;
    localparam logic [7:0] CODE_S     = 8'h1B;
    localparam logic [7:0] CODE_A     = 8'h1C;
    localparam logic [7:0] CODE_D     = 8'h23;
`endif

    // Odd parity: the 8 data bits plus the parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_s3_q;
    logic ps2_data_s1_q, ps2_data_s2_q;
    logic fe_s;

    rx_state_e        state_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             par_q;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic [7:0]       rx_byte_q;
    logic             byte_valid_q;
    logic             frame_err_q;

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [3:0] arrow_q, arrow_d;   // bit 0 up, 1 down, 2 left, 3 right
    logic [3:0] dir_q;
`ifdef PS2_WASD_EN
    logic [3:0] letter_q, letter_d;
`endif

    // Synchronizers for the asynchronous PS/2 lines; reset to the idle-high bus level.
    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            ps2_clk_s1_q  <= 1'b1;
            ps2_clk_s2_q  <= 1'b1;
            ps2_clk_s3_q  <= 1'b1;
            ps2_data_s1_q <= 1'b1;
            ps2_data_s2_q <= 1'b1;
        end else begin
            ps2_clk_s1_q  <= bus.ps2_clk;
            ps2_clk_s2_q  <= ps2_clk_s1_q;
            ps2_clk_s3_q  <= ps2_clk_s2_q;
            ps2_data_s1_q <= bus.ps2_data;
            ps2_data_s2_q <= ps2_data_s1_q;
        end
    end

    assign fe_s = ps2_clk_s3_q & ~ps2_clk_s2_q;

    // Frame receiver FSM with inactivity timeout; emits byte_valid / frame_err pulses.
    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            state_q      <= ST_IDLE;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            tmo_cnt_q    <= '0;
            rx_byte_q    <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;

            if ((state_q == ST_IDLE) || fe_s) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + CNT_ONE;
            end

            // A stalled partial frame is abandoned without emitting a byte.
            if ((state_q != ST_IDLE) && !fe_s && (tmo_cnt_q == TIMEOUT_LIMIT)) begin
                state_q     <= ST_IDLE;
                frame_err_q <= 1'b1;
            end else if (fe_s) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!ps2_data_s2_q) begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= 3'd0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        shift_q[bit_idx_q] <= ps2_data_s2_q;
                        bit_idx_q          <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= ps2_data_s2_q;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (ps2_data_s2_q && odd_parity_ok(shift_q, par_q)) begin
                            rx_byte_q    <= shift_q;
                            byte_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end else begin
                state_q <= state_q;
            end
        end
    end

    // Make/break sequence decoder; acts in the same cycle as the byte_valid / frame_err pulse.
    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        arrow_d = arrow_q;
`ifdef PS2_WASD_EN
        letter_d = letter_q;
`endif
        if (frame_err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_valid_q) begin
            case (rx_byte_q)
                CODE_EXT: ext_d = 1'b1;
                CODE_BRK: brk_d = 1'b1;
                default: begin
                    if (ext_q) begin
                        case (rx_byte_q)
                            CODE_UP:    arrow_d[0] = ~brk_q;
                            CODE_DOWN:  arrow_d[1] = ~brk_q;
                            CODE_LEFT:  arrow_d[2] = ~brk_q;
                            CODE_RIGHT: arrow_d[3] = ~brk_q;
                            default:    arrow_d    = arrow_q;
                        endcase
                    end else begin
`ifdef PS2_WASD_EN
                        case (rx_byte_q)
                            CODE_W:  letter_d[0] = ~brk_q;
                            CODE_S:  letter_d[1] = ~brk_q;
                            CODE_A:  letter_d[2] = ~brk_q;
                            CODE_D:  letter_d[3] = ~brk_q;
                            default: letter_d    = letter_q;
                        endcase
`else
                        arrow_d = arrow_q;
`endif
                    end
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end else begin
            ext_d = ext_q;
            brk_d = brk_q;
        end
    end

    // Decoder state and registered direction outputs.
    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            arrow_q  <= 4'b0000;
            dir_q    <= 4'b0000;
`ifdef PS2_WASD_EN
            letter_q <= 4'b0000;
`endif
        end else begin
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            arrow_q  <= arrow_d;
`ifdef PS2_WASD_EN
            letter_q <= letter_d;
            dir_q    <= arrow_d | letter_d;
`else
            dir_q    <= arrow_d;
`endif
        end
    end

    assign bus.up         = dir_q[0];
    assign bus.down       = dir_q[1];
    assign bus.left       = dir_q[2];
    assign bus.right      = dir_q[3];
    assign bus.rx_byte    = rx_byte_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.frame_err  = frame_err_q;
endmodule
